// File: rtl/steer_pkg.sv
// Shared types and constants for the steering scheduler: FSM state encoding,
// angle width and a one-hot to index helper.
package steer_pkg;

    localparam int unsigned ANGLE_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RUN,
        FINISH
    } state_t;

    function automatic logic [2:0] onehot_idx(input logic [7:0] vec);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/steer_scheduler_if.sv
// Scheduler <-> pid handshake bundle; the scheduler drives the master side.
interface steer_scheduler_if;
    import steer_pkg::*;

    logic [ANGLE_W-1:0] pid_target_angle;
    logic [ANGLE_W-1:0] pid_current_angle;
    logic               pid_angle_update;
    logic               pid_pwm_enable;
    logic               pid_abort_angle;
    logic               pid_angle_done;
    logic               pid_startup_fail;

    modport master (
        output pid_target_angle, pid_current_angle, pid_angle_update,
               pid_pwm_enable, pid_abort_angle,
        input  pid_angle_done, pid_startup_fail
    );

    modport slave (
        input  pid_target_angle, pid_current_angle, pid_angle_update,
               pid_pwm_enable, pid_abort_angle,
        output pid_angle_done, pid_startup_fail
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping at N-1.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [N-1:0] grant
);

    logic [2*N-1:0] rot_req;
    logic [2*N-1:0] rot_grant;
    logic [N-1:0]   low;
    logic [N-1:0]   first;

    // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
    assign rot_req   = {req, req} >> ptr;
    assign low       = rot_req[N-1:0];
    assign first     = low & (~low + 1'b1);
    assign rot_grant = (2*N)'(first) << ptr;
    assign grant     = rot_grant[N-1:0] | rot_grant[2*N-1:N];

endmodule

// File: rtl/steer_scheduler.sv
// Steering scheduler: round-robin sharing of one pid among NUM_WHEELS requesters.
// Define STEER_TIMEOUT_EN to build the RUN-cycle move timeout (timeout_limit).
module steer_scheduler
    import steer_pkg::*;
#(
    parameter int unsigned NUM_WHEELS = 4,
    parameter int unsigned TMO_W      = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_WHEELS-1:0]         move_req,
    input  logic [NUM_WHEELS*ANGLE_W-1:0] target_angles,
    input  logic [NUM_WHEELS*ANGLE_W-1:0] current_angles,
    input  logic                          abort_all,
    input  logic [TMO_W-1:0]              timeout_limit,
    steer_scheduler_if.master             pid,
    output logic [2:0]                    active_wheel,
    output logic                          busy,
    output logic [NUM_WHEELS-1:0]         move_done,
    output logic [NUM_WHEELS-1:0]         move_fail
);

    state_t                state, state_next;
    logic [NUM_WHEELS-1:0] pending, grant, wheel_sel, fail_set, grant_clr;
    logic [2:0]            wheel_q, ptr, win_idx;
    logic [ANGLE_W-1:0]    target_q;
    logic                  success_q, timeout_q, take, tmo_hit;

    rr_arbiter #(.N(NUM_WHEELS)) u_arb (
        .req   (pending),
        .ptr   (ptr),
        .grant (grant)
    );

    assign take      = (state == IDLE) && !abort_all && (|pending);
    assign win_idx   = onehot_idx(8'(grant));
    assign grant_clr = take ? grant : '0;
    assign wheel_sel = NUM_WHEELS'(1) << wheel_q;

`ifdef STEER_TIMEOUT_EN
    logic [TMO_W-1:0] run_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)          run_cnt <= '0;
        else if (state == RUN) run_cnt <= run_cnt + 1'b1;
        else                   run_cnt <= '0;
    end

    // Fires during the RUN cycle that completes timeout_limit RUN cycles.
    assign tmo_hit = (timeout_limit != '0) && ((run_cnt + 1'b1) == timeout_limit);
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_limit;
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pending   <= '0;
            wheel_q   <= '0;
            ptr       <= '0;
            target_q  <= '0;
            success_q <= 1'b0;
            timeout_q <= 1'b0;
            move_fail <= '0;
        end else begin
            state     <= state_next;
            pending   <= abort_all ? '0 : ((pending & ~grant_clr) | move_req);
            move_fail <= (move_fail & ~move_req) | fail_set;
            if (take) begin
                wheel_q  <= win_idx;
                target_q <= ANGLE_W'(target_angles >> (ANGLE_W * win_idx));
                ptr      <= (win_idx == 3'(NUM_WHEELS - 1)) ? '0 : win_idx + 3'd1;
            end
            if (state == RUN) begin
                success_q <= pid.pid_angle_done;
                timeout_q <= !pid.pid_angle_done && !pid.pid_startup_fail && tmo_hit;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (abort_all) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (|pending) state_next = GRANT;
                GRANT:   state_next = RUN;
                RUN:     if (pid.pid_angle_done || pid.pid_startup_fail || tmo_hit)
                             state_next = FINISH;
                FINISH:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy                  = (state != IDLE);
        active_wheel          = busy ? wheel_q : '0;
        pid.pid_target_angle  = target_q;
        pid.pid_current_angle = busy ? ANGLE_W'(current_angles >> (ANGLE_W * wheel_q)) : '0;
        pid.pid_angle_update  = (state == GRANT) && !abort_all;
        pid.pid_pwm_enable    = (state == RUN);
        pid.pid_abort_angle   = (abort_all && busy) || ((state == FINISH) && timeout_q);
        move_done             = ((state == FINISH) && success_q && !abort_all) ? wheel_sel : '0;
        fail_set              = ((state == FINISH) && !success_q && !abort_all) ? wheel_sel : '0;
    end

endmodule
